// File: rtl/sm_cfg_loader.sv
// sm_cfg_loader: serial configuration loader for the 4-sided switch matrix.
// Hunts for a sync word, shifts in NE route entries, validates them and
// commits the whole set atomically to cfg_out.
// Optional even-parity trailer bit: define CFG_PARITY_EN.
module sm_cfg_loader #(
  parameter int          N_TB      = 5,
  parameter int          N_LR      = 4,
  parameter int          ENTRY_W   = 6,
  parameter int          SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_valid,
  input  logic                                   cfg_bit,
  output logic                                   cfg_ready,
  input  logic                                   cfg_abort,
  output logic [(2*N_TB+2*N_LR)*ENTRY_W-1:0]     cfg_out,
  output logic                                   cfg_done,
  output logic                                   cfg_err,
  output logic                                   cfg_loaded
);

  localparam int NE     = 2*N_TB + 2*N_LR;
  localparam int CFG_W  = NE*ENTRY_W;
  localparam int BCNT_W = $clog2(ENTRY_W);
  localparam int ECNT_W = $clog2(NE);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LOAD,
    ST_PAR,
    ST_COMMIT,
    ST_FAIL
  } state_e;

  state_e              state_q,  state_d;
  logic [SYNC_W-1:0]   sync_q,   sync_d;
  logic [ENTRY_W-2:0]  ent_sr_q, ent_sr_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ECNT_W-1:0]   ent_cnt_q, ent_cnt_d;
  logic [CFG_W-1:0]    shadow_q, shadow_d;
  logic                bad_q,    bad_d;
  logic [CFG_W-1:0]    out_q,    out_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;
  logic                loaded_q, loaded_d;
  logic                ready_q,  ready_d;
`ifdef CFG_PARITY_EN
  logic                par_q,    par_d;
`endif

  logic                accept;
  logic [ENTRY_W-1:0]  new_entry;
  logic                new_legal;

  // Route entry legality: side code and source index range for that side.
  function automatic logic entry_legal(input logic [ENTRY_W-1:0] e);
    logic [ENTRY_W-4:0] idx;
    logic [2:0]         side;
    logic               ok;
    idx  = e[ENTRY_W-1:3];
    side = e[2:0];
    case (side)
      3'd0:       ok = (idx == '0);
      3'd1, 3'd3: ok = (int'(idx) < N_TB);
      3'd2, 3'd4: ok = (int'(idx) < N_LR);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign accept    = cfg_valid && ready_q;
  assign new_entry = {ent_sr_q, cfg_bit};
  assign new_legal = entry_legal(new_entry);

  // Next-state and datapath update for the loader FSM.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    ent_sr_d  = ent_sr_q;
    bit_cnt_d = bit_cnt_q;
    ent_cnt_d = ent_cnt_q;
    shadow_d  = shadow_q;
    bad_d     = bad_q;
    out_d     = out_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    loaded_d  = loaded_q;
`ifdef CFG_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      ST_HUNT: begin
        if (cfg_abort) begin
          sync_d = '0;
        end else if (accept) begin
          sync_d = {sync_q[SYNC_W-2:0], cfg_bit};
          if ({sync_q[SYNC_W-2:0], cfg_bit} == SYNC_WORD) begin
            // Sync history is dropped on lock so stale bits can never
            // combine with the next frame's lead-in into a false sync.
            state_d   = ST_LOAD;
            sync_d    = '0;
            bit_cnt_d = '0;
            ent_cnt_d = '0;
            bad_d     = 1'b0;
`ifdef CFG_PARITY_EN
            par_d     = 1'b0;
`endif
          end
        end
      end

      ST_LOAD: begin
        if (cfg_abort) begin
          state_d   = ST_HUNT;
          shadow_d  = '0;
          bad_d     = 1'b0;
          sync_d    = '0;
          bit_cnt_d = '0;
          ent_cnt_d = '0;
        end else if (accept) begin
          ent_sr_d = new_entry[ENTRY_W-2:0];
`ifdef CFG_PARITY_EN
          par_d    = par_q ^ cfg_bit;
`endif
          if (bit_cnt_q == BCNT_W'(ENTRY_W-1)) begin
            bit_cnt_d = '0;
            for (int unsigned k = 0; k < NE; k++) begin
              if (ent_cnt_q == ECNT_W'(k))
                shadow_d[k*ENTRY_W +: ENTRY_W] = new_entry;
            end
            if (!new_legal)
              bad_d = 1'b1;
            if (ent_cnt_q == ECNT_W'(NE-1)) begin
              ent_cnt_d = '0;
`ifdef CFG_PARITY_EN
              state_d = ST_PAR;
`else
              state_d = (bad_q || !new_legal) ? ST_FAIL : ST_COMMIT;
`endif
            end else begin
              ent_cnt_d = ent_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      ST_PAR: begin
        if (cfg_abort) begin
          state_d  = ST_HUNT;
          shadow_d = '0;
          bad_d    = 1'b0;
          sync_d   = '0;
        end else if (accept) begin
`ifdef CFG_PARITY_EN
          state_d = (bad_q || (par_q ^ cfg_bit)) ? ST_FAIL : ST_COMMIT;
`else
          state_d = ST_HUNT;
`endif
        end
      end

      ST_COMMIT: begin
        out_d    = shadow_q;
        done_d   = 1'b1;
        loaded_d = 1'b1;
        state_d  = ST_HUNT;
      end

      ST_FAIL: begin
        state_d = ST_HUNT;
        if (cfg_abort) begin
          shadow_d = '0;
          bad_d    = 1'b0;
          sync_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end

      default: state_d = ST_HUNT;
    endcase

    ready_d = (state_d == ST_HUNT) || (state_d == ST_LOAD) || (state_d == ST_PAR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      sync_q    <= '0;
      ent_sr_q  <= '0;
      bit_cnt_q <= '0;
      ent_cnt_q <= '0;
      shadow_q  <= '0;
      bad_q     <= 1'b0;
      out_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      loaded_q  <= 1'b0;
      ready_q   <= 1'b1;
`ifdef CFG_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      ent_sr_q  <= ent_sr_d;
      bit_cnt_q <= bit_cnt_d;
      ent_cnt_q <= ent_cnt_d;
      shadow_q  <= shadow_d;
      bad_q     <= bad_d;
      out_q     <= out_d;
      done_q    <= done_d;
      err_q     <= err_d;
      loaded_q  <= loaded_d;
      ready_q   <= ready_d;
`ifdef CFG_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign cfg_ready  = ready_q;
  assign cfg_out    = out_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign cfg_loaded = loaded_q;

endmodule

// File: tb/tb_sm_cfg_loader.sv
// tb_sm_cfg_loader: directed self-checking bench for sm_cfg_loader.
// Define CFG_PARITY_EN for both bench and RTL to exercise the parity trailer.
module tb_sm_cfg_loader;

  localparam int NE    = 18;
  localparam int CFG_W = NE*6;

  logic             clk;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic             cfg_abort;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_done;
  logic             cfg_err;
  logic             cfg_loaded;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [CFG_W-1:0] frame_a;
  logic [CFG_W-1:0] frame_b;
  logic [CFG_W-1:0] frame_c;
  logic [CFG_W-1:0] frame_bad;

  sm_cfg_loader #(.N_TB(5), .N_LR(4), .ENTRY_W(6), .SYNC_W(8), .SYNC_WORD(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .cfg_out    (cfg_out),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .cfg_loaded (cfg_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (cfg_done) done_cnt++;
    if (cfg_err)  err_cnt++;
  end

  // Offer one bit at a negedge; it is taken at the following posedge.
  task automatic send_bit(input logic b);
    int unsigned w;
    w = 0;
    cfg_valid = 1'b1;
    cfg_bit   = b;
    while (!cfg_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cfg_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: cfg_ready=%b required 1", cfg_ready);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'hA5;
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  // Sync word then the first nbits payload bits, entries MSB first;
  // optional 20-cycle valid-low stall before payload bit stall_at.
  task automatic send_head(input logic [CFG_W-1:0] v, input int nbits, input int stall_at);
    send_sync();
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) repeat (20) @(negedge clk);
      send_bit(v[(i/6)*6 + (5 - (i%6))]);
    end
  endtask

  // Full frame; leaves the bench at the negedge after the last accepted bit.
  task automatic send_frame(input logic [CFG_W-1:0] v, input int stall_at, input logic pflip);
    send_head(v, CFG_W, stall_at);
`ifdef CFG_PARITY_EN
    send_bit((^v) ^ pflip);
`else
    if (pflip) $display("note: parity flip ignored without parity trailer");
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cfg_out !== '0) begin errors++; $display("FAIL reset_out: got %h required 0", cfg_out); end
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded: got %b required 0", cfg_loaded); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", cfg_ready); end
    checks++; if ({cfg_done, cfg_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b required 00", {cfg_done, cfg_err}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_legal();
    int d0;
    frame_a = '0;
    frame_a[5:0]   = 6'b001_010;
    frame_a[83:78] = 6'b100_001;
    d0 = done_cnt;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_frame(frame_a, -1, 1'b0);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL legal_early_done: got %b required 0", cfg_done); end
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL legal_commit_ready: got %b required 0", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL legal_done: got %b required 1", cfg_done); end
    checks++; if (cfg_out[5:0] !== 6'h0A) begin errors++; $display("FAIL legal_top0: got %h required 0a", cfg_out[5:0]); end
    checks++; if (cfg_out[83:78] !== 6'h21) begin errors++; $display("FAIL legal_left3: got %h required 21", cfg_out[83:78]); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL legal_out: got %h required %h", cfg_out, frame_a); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL legal_loaded: got %b required 1", cfg_loaded); end
    @(negedge clk); #1;
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL legal_done_width: got %b required 0", cfg_done); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL legal_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_illegal();
    int d0;
    int e0;
    d0 = done_cnt; e0 = err_cnt;
    frame_bad = frame_a;
    frame_bad[47:42] = 6'b000_110;
    send_frame(frame_bad, -1, 1'b0);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_side_err: got %b required 1", cfg_err); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL illegal_side_out: got %h required %h", cfg_out, frame_a); end
    frame_bad = frame_a;
    frame_bad[77:72] = 6'b100_010;
    send_frame(frame_bad, -1, 1'b0);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL illegal_index_err: got %b required 1", cfg_err); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL illegal_index_out: got %h required %h", cfg_out, frame_a); end
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL illegal_no_done: got %0d required 0", done_cnt - d0); end
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL illegal_err_count: got %0d required 2", err_cnt - e0); end
    checks++; if (cfg_loaded !== 1'b1) begin errors++; $display("FAIL illegal_loaded: got %b required 1", cfg_loaded); end
  endtask

  task automatic test_stall();
    frame_c = '0;
    frame_c[11:6]    = 6'b011_011;
    frame_c[59:54]   = 6'b010_100;
    frame_c[107:102] = 6'b000_000;
    frame_c[101:96]  = 6'b011_010;
    send_frame(frame_c, 50, 1'b0);
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b required 1", cfg_done); end
    checks++; if (cfg_out !== frame_c) begin errors++; $display("FAIL stall_out: got %h required %h", cfg_out, frame_c); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int d0;
    int e0;
    d0 = done_cnt; e0 = err_cnt;
    send_head(frame_a, 66, -1);
    cfg_abort = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL abort_no_pulse: got %0d required 0", (done_cnt - d0) + (err_cnt - e0)); end
    checks++; if (cfg_out !== frame_c) begin errors++; $display("FAIL abort_out: got %h required %h", cfg_out, frame_c); end
    send_frame(frame_a, -1, 1'b0);
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL abort_next_done: got %b required 1", cfg_done); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL abort_next_out: got %h required %h", cfg_out, frame_a); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    frame_b = '0;
    frame_b[17:12] = 6'b001_100;
    frame_b[65:60] = 6'b100_011;
    send_frame(frame_c, -1, 1'b0);
    // Hold a valid bit across the COMMIT cycle; it must not be taken.
    cfg_valid = 1'b1; cfg_bit = 1'b1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL b2b_commit_ready: got %b required 0", cfg_ready); end
    @(negedge clk);
    checks++; if (cfg_out !== frame_c) begin errors++; $display("FAIL b2b_first_out: got %h required %h", cfg_out, frame_c); end
    send_frame(frame_b, -1, 1'b0);
    @(negedge clk);
    checks++; if (cfg_out !== frame_b) begin errors++; $display("FAIL b2b_second_out: got %h required %h", cfg_out, frame_b); end
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); end
  endtask

  task automatic test_mid_reset();
    int d0;
    send_head(frame_a, 30, -1);
    rst_n = 1'b0;
    #1;
    checks++; if (cfg_out !== '0) begin errors++; $display("FAIL midrst_out: got %h required 0", cfg_out); end
    checks++; if (cfg_loaded !== 1'b0) begin errors++; $display("FAIL midrst_loaded: got %b required 0", cfg_loaded); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b required 1", cfg_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    send_frame(frame_b, -1, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_done_count: got %0d required 1", done_cnt - d0); end
    checks++; if (cfg_out !== frame_b) begin errors++; $display("FAIL midrst_out_after: got %h required %h", cfg_out, frame_b); end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    send_frame(frame_a, -1, 1'b0);
    @(negedge clk);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL par_good_done: got %b required 1", cfg_done); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL par_good_out: got %h required %h", cfg_out, frame_a); end
    @(negedge clk);
    send_frame(frame_c, -1, 1'b1);
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL par_bad_err: got %b required 1", cfg_err); end
    checks++; if (cfg_out !== frame_a) begin errors++; $display("FAIL par_bad_out: got %h required %h", cfg_out, frame_a); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_stall();
    test_abort();
    test_back_to_back();
    test_mid_reset();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
